// File: rtl/bkg_pixel_fetch.sv
// bkg_pixel_fetch
// Read-side client of the background image RAM (IMG_W x IMG_H texels,
// 24-bit {R,G,B}, 1-cycle registered read). Turns the VGA beam position
// into a texel address with 4x upscaling and a per-frame vertical scroll
// that wraps modulo the image height. It returns the registered colour
// three clocks after the pixel is presented.
//
// Build option: define BKG_FETCH_DIM_EN to add the 'dim' input. When dim is
// set, each colour channel is halved for that pixel.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   DrawX/DrawY  screen column/row from the VGA controller
//   pixel_valid  active-video qualifier
//   frame_start  one-cycle pulse at start of vertical blank
//   scroll_delta texel rows to advance per frame (saturated to IMG_H-1)
//   scroll_clr   zeroes the scroll offset; wins over frame_start
//   ram_data     RAM read data, one cycle after read_address
//   dim          (BKG_FETCH_DIM_EN only) halve this pixel's brightness
//   read_address registered RAM read address
//   rgb          registered pixel colour, black outside active video
//   rgb_valid    rgb belongs to an active pixel
//   scroll_y     current scroll offset, 0..IMG_H-1
module bkg_pixel_fetch #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 160,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pixel_valid,
    input  logic              frame_start,
    input  logic [7:0]        scroll_delta,
    input  logic              scroll_clr,
    input  logic [23:0]       ram_data,
`ifdef BKG_FETCH_DIM_EN
    input  logic              dim,
`endif
    output logic [ADDR_W-1:0] read_address,
    output logic [23:0]       rgb,
    output logic              rgb_valid,
    output logic [7:0]        scroll_y
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [7:0]        scroll_q;
    logic [7:0]        delta_sat;
    logic [8:0]        scroll_sum;
    logic [7:0]        scroll_wrapped;

    logic [9:0]        x_tex;
    logic [9:0]        y_tex;
    logic [CW-1:0]     col;
    logic [RW-1:0]     ty;
    logic [RW:0]       row_sum;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] addr_next;

    logic              v1;
    logic              v2;
    logic              dim1;
    logic              dim2;
    logic              dim_in;

`ifdef BKG_FETCH_DIM_EN
    assign dim_in = dim;
`else
    assign dim_in = 1'b0;
`endif

    // Scroll offset: saturate the step so one conditional subtract wraps it.
    always_comb begin
        delta_sat      = (scroll_delta > 8'(IMG_H - 1)) ? 8'(IMG_H - 1) : scroll_delta;
        scroll_sum     = {1'b0, scroll_q} + {1'b0, delta_sat};
        scroll_wrapped = (scroll_sum >= 9'(IMG_H)) ? 8'(scroll_sum - 9'(IMG_H))
                                                    : scroll_sum[7:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            scroll_q <= 8'd0;
        else if (scroll_clr)
            scroll_q <= 8'd0;
        else if (frame_start)
            scroll_q <= scroll_wrapped;
    end

    assign scroll_y = scroll_q;

    // Texel coordinates with clamping for beam positions past the image.
    always_comb begin
        x_tex   = DrawX >> SCALE_SHIFT;
        y_tex   = DrawY >> SCALE_SHIFT;
        col     = (x_tex > 10'(IMG_W - 1)) ? CW'(IMG_W - 1) : x_tex[CW-1:0];
        ty      = (y_tex > 10'(IMG_H - 1)) ? RW'(IMG_H - 1) : y_tex[RW-1:0];
        row_sum = (RW + 1)'(ty) + (RW + 1)'(scroll_q);
        row     = (row_sum >= (RW + 1)'(IMG_H)) ? RW'(row_sum - (RW + 1)'(IMG_H))
                                                : RW'(row_sum);
        // row*160 as (row<<7)+(row<<5) keeps a multiplier out of the netlist.
        addr_next = (ADDR_W'(row) << 7) + (ADDR_W'(row) << 5) + ADDR_W'(col);
    end

    // S1 address, S2 RAM access, S3 output register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            read_address <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            dim1         <= 1'b0;
            dim2         <= 1'b0;
            rgb          <= 24'h0;
            rgb_valid    <= 1'b0;
        end else begin
            read_address <= addr_next;
            v1           <= pixel_valid;
            dim1         <= dim_in;
            v2           <= v1;
            dim2         <= dim1;
            rgb_valid    <= v2;
            if (!v2)
                rgb <= 24'h0;
            else if (dim2)
                rgb <= {1'b0, ram_data[23:17], 1'b0, ram_data[15:9], 1'b0, ram_data[7:1]};
            else
                rgb <= ram_data;
        end
    end

endmodule

// File: tb/tb_bkg_pixel_fetch.sv
`timescale 1ns/1ps
module tb_bkg_pixel_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        pixel_valid, frame_start, scroll_clr;
    logic [7:0]  scroll_delta;
    logic [23:0] ram_data;
    logic [14:0] read_address;
    logic [23:0] rgb;
    logic        rgb_valid;
    logic [7:0]  scroll_y;
`ifdef BKG_FETCH_DIM_EN
    logic        dim;
`endif

    int total = 0;
    int bad   = 0;
    int sc    = 0;          // model scroll offset

    logic [23:0] mem [0:25599];
    logic [14:0] got_addr;
    logic [23:0] got_rgb;
    logic        got_valid;

    always #5 Clk = ~Clk;

    bkg_pixel_fetch dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .pixel_valid(pixel_valid), .frame_start(frame_start),
        .scroll_delta(scroll_delta), .scroll_clr(scroll_clr),
        .ram_data(ram_data),
`ifdef BKG_FETCH_DIM_EN
        .dim(dim),
`endif
        .read_address(read_address), .rgb(rgb), .rgb_valid(rgb_valid),
        .scroll_y(scroll_y)
    );

    // Behavioural RAM with a registered read.
    always @(posedge Clk)
        ram_data <= (int'(read_address) < 25600) ? mem[read_address] : 24'h0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached got=running want=finished");
        $fatal(1, "watchdog");
    end

    function automatic int model_addr(input int x, input int y, input int s);
        int tx, tyy;
        tx  = x / 4;  if (tx > 159) tx = 159;
        tyy = y / 4;  if (tyy > 159) tyy = 159;
        return ((tyy + s) % 160) * 160 + tx;
    endfunction

    function automatic int model_scroll(input int s, input bit fs, input bit clr, input int d);
        int dd;
        if (clr) return 0;
        if (!fs) return s;
        dd = (d > 159) ? 159 : d;
        return (s + dd) % 160;
    endfunction

    function automatic logic [23:0] model_rgb(input bit v, input bit dm, input logic [23:0] w);
        if (!v) return 24'h0;
        if (dm) return {w[23:16] / 8'd2, w[15:8] / 8'd2, w[7:0] / 8'd2};
        return w;
    endfunction

    task automatic idle_inputs();
        DrawX = 0; DrawY = 0; pixel_valid = 0; frame_start = 0;
        scroll_clr = 0; scroll_delta = 0;
`ifdef BKG_FETCH_DIM_EN
        dim = 0;
`endif
    endtask

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    // Present one pixel, capture its address after 1 edge and colour after 3.
    task automatic pixel(input int x, input int y, input bit v, input bit dm);
        DrawX = 10'(x); DrawY = 10'(y); pixel_valid = v;
`ifdef BKG_FETCH_DIM_EN
        dim = dm;
`endif
        tick();
        got_addr = read_address;
        pixel_valid = 0;
`ifdef BKG_FETCH_DIM_EN
        dim = 0;
`endif
        tick(); tick();
        got_rgb = rgb; got_valid = rgb_valid;
    endtask

    task automatic frame(input bit fs, input bit clr, input int d);
        frame_start = fs; scroll_clr = clr; scroll_delta = 8'(d);
        sc = model_scroll(sc, fs, clr, d);
        tick();
        frame_start = 0; scroll_clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1;
        tick(); tick();
        total++; if (read_address !== 15'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", read_address); end
        total++; if (rgb !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h want=000000", rgb); end
        total++; if (rgb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rgb_valid); end
        total++; if (scroll_y !== 8'd0) begin bad++; $display("FAIL reset_scroll got=%0d want=0", scroll_y); end
        Reset = 0; sc = 0;
        // Stream valid pixels, then reset mid-stream: nothing may come out.
        pixel_valid = 1; DrawX = 40; DrawY = 40;
        tick(); tick();
        Reset = 1; tick();
        Reset = 0; pixel_valid = 0;
        total++; if (rgb_valid !== 1'b0) begin bad++; $display("FAIL flush_0 got=%b want=0", rgb_valid); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++; if (rgb_valid !== 1'b0) begin bad++; $display("FAIL flush_%0d got=%b want=0", i, rgb_valid); end
        end
    endtask

    task automatic test_origin();
        mem[0] = 24'h1A2B3C;
        pixel(0, 0, 1, 0);
        total++; if (got_addr !== 15'd0) begin bad++; $display("FAIL origin_addr got=%0d want=0", got_addr); end
        total++; if (got_rgb !== 24'h1A2B3C) begin bad++; $display("FAIL origin_rgb got=%h want=1a2b3c", got_rgb); end
        total++; if (got_valid !== 1'b1) begin bad++; $display("FAIL origin_valid got=%b want=1", got_valid); end
    endtask

    task automatic test_corner();
        pixel(639, 479, 1, 0);
        total++; if (got_addr !== 15'd19199) begin bad++; $display("FAIL corner_addr got=%0d want=19199", got_addr); end
        total++; if (got_rgb !== mem[19199]) begin bad++; $display("FAIL corner_rgb got=%h want=%h", got_rgb, mem[19199]); end
        pixel(700, 0, 1, 0);
        total++; if (got_addr !== 15'd159) begin bad++; $display("FAIL clampx_addr got=%0d want=159", got_addr); end
        pixel(0, 1000, 1, 0);
        total++; if (got_addr !== 15'd25440) begin bad++; $display("FAIL clampy_addr got=%0d want=25440", got_addr); end
    endtask

    task automatic test_scroll_wrap();
        int want [4] = '{50, 100, 150, 40};
        for (int i = 0; i < 4; i++) begin
            frame(1, 0, 50);
            total++; if (scroll_y !== 8'(want[i])) begin bad++; $display("FAIL wrap_%0d got=%0d want=%0d", i, scroll_y, want[i]); end
        end
        frame(1, 0, 119);
        total++; if (scroll_y !== 8'd159) begin bad++; $display("FAIL to159 got=%0d want=159", scroll_y); end
        pixel(8, 4, 1, 0);
        total++; if (got_addr !== 15'd2) begin bad++; $display("FAIL wrap_addr got=%0d want=2", got_addr); end
        total++; if (got_rgb !== mem[2]) begin bad++; $display("FAIL wrap_rgb got=%h want=%h", got_rgb, mem[2]); end
    endtask

    task automatic test_priority_sat();
        frame(1, 1, 30);
        total++; if (scroll_y !== 8'd0) begin bad++; $display("FAIL clr_prio got=%0d want=0", scroll_y); end
        frame(1, 0, 200);
        total++; if (scroll_y !== 8'd159) begin bad++; $display("FAIL sat got=%0d want=159", scroll_y); end
        frame(0, 0, 77);
        total++; if (scroll_y !== 8'd159) begin bad++; $display("FAIL hold got=%0d want=159", scroll_y); end
        frame(0, 1, 0);
        total++; if (scroll_y !== 8'd0) begin bad++; $display("FAIL clr got=%0d want=0", scroll_y); end
    endtask

    task automatic test_blanking();
        mem[322] = 24'hC0FFEE;
        pixel(8, 8, 0, 0);
        total++; if (got_addr !== 15'd322) begin bad++; $display("FAIL blank_addr got=%0d want=322", got_addr); end
        total++; if (got_rgb !== 24'h0) begin bad++; $display("FAIL blank_rgb got=%h want=000000", got_rgb); end
        total++; if (got_valid !== 1'b0) begin bad++; $display("FAIL blank_valid got=%b want=0", got_valid); end
    endtask

`ifdef BKG_FETCH_DIM_EN
    task automatic test_dim();
        mem[5] = 24'hFF8001;
        pixel(20, 0, 1, 1);
        total++; if (got_rgb !== 24'h7F4000) begin bad++; $display("FAIL dim_rgb got=%h want=7f4000", got_rgb); end
        pixel(20, 0, 1, 0);
        total++; if (got_rgb !== 24'hFF8001) begin bad++; $display("FAIL undim_rgb got=%h want=ff8001", got_rgb); end
    endtask
`endif

    // Random back-to-back stream with scroll activity mixed in.
    task automatic test_back_to_back(input int n);
        logic [23:0] exp_rgb [0:255];
        bit          exp_v   [0:255];
        int x, y, d, a;
        bit v, fs, clr, dm;
        for (int i = 0; i < n; i++) begin
            x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
            v = ($urandom_range(0, 7) != 0);
            fs = ($urandom_range(0, 5) == 0); clr = ($urandom_range(0, 29) == 0);
            d = $urandom_range(0, 255);
            dm = 0;
`ifdef BKG_FETCH_DIM_EN
            dm = $urandom_range(0, 1);
            dim = dm;
`endif
            DrawX = 10'(x); DrawY = 10'(y); pixel_valid = v;
            frame_start = fs; scroll_clr = clr; scroll_delta = 8'(d);
            a = model_addr(x, y, sc);
            exp_rgb[i] = model_rgb(v, dm, mem[a]);
            exp_v[i]   = v;
            sc = model_scroll(sc, fs, clr, d);
            tick();
            total++; if (read_address !== 15'(a)) begin bad++; $display("FAIL b2b_addr[%0d] got=%0d want=%0d", i, read_address, a); end
            total++; if (scroll_y !== 8'(sc)) begin bad++; $display("FAIL b2b_scroll[%0d] got=%0d want=%0d", i, scroll_y, sc); end
            if (i >= 2) begin
                total++; if (rgb !== exp_rgb[i-2] || rgb_valid !== exp_v[i-2]) begin
                    bad++; $display("FAIL b2b_rgb[%0d] got=%h/%b want=%h/%b", i-2, rgb, rgb_valid, exp_rgb[i-2], exp_v[i-2]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 25600; i++) mem[i] = 24'($urandom);
        test_reset();
        test_origin();
        test_corner();
        test_scroll_wrap();
        test_priority_sat();
        test_blanking();
`ifdef BKG_FETCH_DIM_EN
        test_dim();
`endif
        test_back_to_back(250);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bkg_pixel_fetch.md
Name: bkg_pixel_fetch

Overview:
- Read-side client of the 160x160, 24-bit background image RAM; the RAM has a 1-cycle registered read.
- Converts the VGA controller's DrawX/DrawY into RAM read addresses and returns registered RGB to the colour mapper.
- Applies 4x pixel upscaling and a per-frame vertical scroll that wraps modulo the image height. This produces the Doodle Jump scrolling background.

Parameters:
- IMG_W, 160, image width in texels.
- IMG_H, 160, image height in texels.
- SCALE_SHIFT, 2, screen-pixel to texel shift (4x).
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current screen column, 0..639 active.
- DrawY  in  10  current screen row, 0..479 active.
- pixel_valid  in  1  high during the active video region.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- scroll_delta  in  8  texel rows to advance per frame.
- scroll_clr  in  1  zeroes the scroll offset (game restart).
- ram_data  in  24  RAM read data, valid 1 cycle after read_address.
- read_address  out  ADDR_W  registered RAM read address.
- rgb  out  24  registered pixel colour {R,G,B}.
- rgb_valid  out  1  rgb corresponds to an active pixel.
- scroll_y  out  8  current scroll offset, 0..IMG_H-1.

Behaviour:
- Reset values: read_address=0, rgb=0, rgb_valid=0, scroll_y=0. Reset also clears all internal valid pipeline bits.
  - Reset mid-stream flushes in-flight pixels; no stale rgb_valid appears afterward.
- Scroll register, updated at the clock edge:
  - scroll_clr=1: scroll_y <= 0. This takes priority over a simultaneous frame_start.
  - else frame_start=1: d = min(scroll_delta, IMG_H-1), then scroll_y <= (scroll_y + d) mod IMG_H. The sum is at most 318, so the wrap is a single conditional subtract of IMG_H.
  - else: hold.
  - The new value applies to pixels presented on the cycle after the update.
- Address stage (S1, registered):
  - col = DrawX >> SCALE_SHIFT, clamped to IMG_W-1.
  - ty = DrawY >> SCALE_SHIFT, clamped to IMG_H-1.
  - row = (ty + scroll_y) mod IMG_H, using a single conditional subtract.
  - read_address <= row*IMG_W + col. Use the shift-add form for 160, (row<<7)+(row<<5). No multiplier is inferred.
  - v1 <= pixel_valid.
- RAM stage (S2): the RAM returns ram_data; v2 <= v1.
- Output stage (S3):
  - rgb <= v2 ? ram_data : 24'h0.
  - rgb_valid <= v2.
- Latency: pixel inputs sampled at edge N give read_address after edge N, and rgb/rgb_valid after edge N+2.
  - Fixed 3-stage pipeline, one pixel per clock, no stalls.
  - The VGA controller offsets its sync outputs by 3 cycles to align.
- The address is computed even when pixel_valid=0; only rgb is gated to black.
- The block never writes the RAM.

Optional Feature:
- Macro: BKG_FETCH_DIM_EN.
- Defined:
  - Adds input port dim (1 bit), sampled alongside pixel and delayed through the pipeline with the valid bits.
  - At S3, when the delayed dim=1 and v2=1, each 8-bit channel is shifted right by 1: rgb = {R>>1, G>>1, B>>1}. This is used for pause/game-over screens.
  - Latency is unchanged.
- Undefined:
  - No dim port; rgb is exactly the RAM data.

Test Plan:
- Reset then idle: hold Reset 2 cycles -> read_address=0, rgb=0, rgb_valid=0, scroll_y=0. Assert Reset while pixel_valid=1 streams -> rgb_valid=0 on the following 3 edges.
- Origin pixel, scroll 0: DrawX=0, DrawY=0, pixel_valid=1, RAM preloaded mem[0]=24'h1A2B3C -> read_address=0 after 1 cycle; rgb=24'h1A2B3C, rgb_valid=1 after 3 cycles.
- Far corner: DrawX=639, DrawY=479 -> col 159, row 119, read_address=19199. Out-of-range DrawX=700 -> col clamped to 159.
- Scroll wrap: scroll_delta=50, four frame_start pulses -> scroll_y = 50, 100, 150, then 40. With scroll_y=159, DrawY=4, DrawX=8 -> row 0, read_address=2.
- Priority and saturation:
  - scroll_clr and frame_start in the same cycle -> scroll_y=0.
  - scroll_delta=200 from 0 -> scroll_y=159.
- Blanking: pixel_valid=0 with mem data nonzero -> rgb=0, rgb_valid=0 3 cycles later. Back-to-back valid pixels stream at 1 per clock with no gaps.
- With BKG_FETCH_DIM_EN: dim=1, data 24'hFF8001 -> rgb=24'h7F4000.
